// File: rtl/otter_pkg.sv
// Shared types for the OTTER decode/execute boundary: ALU codes, operand
// selects, writeback selects and the registered control bundle.
package otter_pkg;

    // ALU operation codes, {func7[5], func3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_MUL  = 4'b1010,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    // ALU operand A source
    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2,
        SRCA_RSVD = 2'd3
    } srca_sel_t;

    // ALU operand B source
    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_RSVD = 2'd3
    } srcb_sel_t;

    // Register file writeback source
    typedef enum logic [1:0] {
        RF_PC4 = 2'd0,
        RF_CSR = 2'd1,
        RF_MEM = 2'd2,
        RF_ALU = 2'd3
    } rf_wr_sel_t;

    // Control portion of the ID/EX bundle; the XLEN-wide data fields are
    // kept beside it so the datapath width stays a module parameter.
    // An all-zero value of this struct is a bubble.
    typedef struct packed {
        logic       valid;
        alu_fun_t   alu_fun;
        logic [4:0] rd_addr;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        rf_wr_sel_t rf_wr_sel;
    } id_ex_t;

endpackage

// File: rtl/otter_operand_sel.sv
// ALU operand muxes evaluated in ID so EX sees operands straight from flops.
module otter_operand_sel
    import otter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [1:0]      srca_sel_i,
    input  logic [1:0]      srcb_sel_i,
    output logic [XLEN-1:0] srca_o,
    output logic [XLEN-1:0] srcb_o
);

    // Operand A: RS1, PC, or zero (reserved code also yields zero)
    always_comb begin
        srca_o = '0;
        case (srca_sel_i)
            SRCA_RS1: srca_o = rs1_i;
            SRCA_PC:  srca_o = pc_i;
            default:  srca_o = '0;
        endcase
    end

    // Operand B: RS2, IMM, constant 4, or zero for the reserved code
    always_comb begin
        srcb_o = '0;
        case (srcb_sel_i)
            SRCB_RS2:  srcb_o = rs2_i;
            SRCB_IMM:  srcb_o = imm_i;
            SRCB_FOUR: srcb_o = XLEN'(4);
            default:   srcb_o = '0;
        endcase
    end

endmodule

// File: rtl/otter_id_ex_reg.sv
// ID/EX pipeline register with pre-selected ALU operands, stall, flush and
// a saturating bubble counter.
module otter_id_ex_reg
    import otter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_VALID,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic [XLEN-1:0]  ID_RS1,
    input  logic [XLEN-1:0]  ID_RS2,
    input  logic [XLEN-1:0]  ID_IMM,
    input  logic [1:0]       ID_SRCA_SEL,
    input  logic [1:0]       ID_SRCB_SEL,
    input  logic [3:0]       ID_ALU_FUN,
    input  logic [4:0]       ID_RD_ADDR,
    input  logic             ID_REG_WE,
    input  logic             ID_MEM_WE,
    input  logic             ID_MEM_RE,
    input  logic [1:0]       ID_RF_WR_SEL,
    input  logic             STALL,
    input  logic             FLUSH,
    output logic             ID_READY,
    output logic             EX_VALID,
    output logic [XLEN-1:0]  EX_PC,
    output logic [XLEN-1:0]  EX_ALU_SRC_A,
    output logic [XLEN-1:0]  EX_ALU_SRC_B,
    output logic [3:0]       EX_ALU_FUN,
    output logic [XLEN-1:0]  EX_RS2,
    output logic [4:0]       EX_RD_ADDR,
    output logic             EX_REG_WE,
    output logic             EX_MEM_WE,
    output logic             EX_MEM_RE,
    output logic [1:0]       EX_RF_WR_SEL,
    output logic [CNT_W-1:0] BUBBLE_CNT
);

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [XLEN-1:0]  srca_sel, srcb_sel;
    id_ex_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  srca_q, srca_d;
    logic [XLEN-1:0]  srcb_q, srcb_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             bubble, load;

    otter_operand_sel #(.XLEN(XLEN)) u_operand_sel (
        .rs1_i      (ID_RS1),
        .pc_i       (ID_PC),
        .rs2_i      (ID_RS2),
        .imm_i      (ID_IMM),
        .srca_sel_i (ID_SRCA_SEL),
        .srcb_sel_i (ID_SRCB_SEL),
        .srca_o     (srca_sel),
        .srcb_o     (srcb_sel)
    );

    // FLUSH overrides STALL; an invalid ID slot becomes a bubble when not stalled
    assign bubble   = FLUSH | (~STALL & ~ID_VALID);
    assign load     = ~FLUSH & ~STALL & ID_VALID;
    assign ID_READY = ~STALL;

    // Next-state: hold by default, then bubble or capture
    always_comb begin
        ctrl_d       = ctrl_q;
        pc_d         = pc_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        rs2_d        = rs2_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            ctrl_d       = '0;
            pc_d         = '0;
            srca_d       = '0;
            srcb_d       = '0;
            rs2_d        = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (load) begin
            ctrl_d.valid     = 1'b1;
            ctrl_d.alu_fun   = alu_fun_t'(ID_ALU_FUN);
            ctrl_d.rd_addr   = ID_RD_ADDR;
            ctrl_d.reg_we    = ID_REG_WE;
            ctrl_d.mem_we    = ID_MEM_WE;
            ctrl_d.mem_re    = ID_MEM_RE;
            ctrl_d.rf_wr_sel = rf_wr_sel_t'(ID_RF_WR_SEL);
            pc_d             = ID_PC;
            srca_d           = srca_sel;
            srcb_d           = srcb_sel;
            rs2_d            = ID_RS2;
        end
    end

    // State register; reset clears the whole bundle and the counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q       <= '0;
            pc_q         <= '0;
            srca_q       <= '0;
            srcb_q       <= '0;
            rs2_q        <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            pc_q         <= pc_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            rs2_q        <= rs2_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign EX_VALID     = ctrl_q.valid;
    assign EX_PC        = pc_q;
    assign EX_ALU_SRC_A = srca_q;
    assign EX_ALU_SRC_B = srcb_q;
    assign EX_ALU_FUN   = ctrl_q.alu_fun;
    assign EX_RS2       = rs2_q;
    assign EX_RD_ADDR   = ctrl_q.rd_addr;
    assign EX_REG_WE    = ctrl_q.reg_we;
    assign EX_MEM_WE    = ctrl_q.mem_we;
    assign EX_MEM_RE    = ctrl_q.mem_re;
    assign EX_RF_WR_SEL = ctrl_q.rf_wr_sel;
    assign BUBBLE_CNT   = bubble_cnt_q;

endmodule

// File: tb/tb_otter_id_ex_reg.sv
// Directed bench for otter_id_ex_reg (4-bit bubble counter to reach saturation).
module tb_otter_id_ex_reg;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ID_VALID;
    logic [31:0] ID_PC, ID_RS1, ID_RS2, ID_IMM;
    logic [1:0]  ID_SRCA_SEL, ID_SRCB_SEL;
    logic [3:0]  ID_ALU_FUN;
    logic [4:0]  ID_RD_ADDR;
    logic        ID_REG_WE, ID_MEM_WE, ID_MEM_RE;
    logic [1:0]  ID_RF_WR_SEL;
    logic        STALL, FLUSH;
    logic        ID_READY, EX_VALID;
    logic [31:0] EX_PC, EX_ALU_SRC_A, EX_ALU_SRC_B, EX_RS2;
    logic [3:0]  EX_ALU_FUN;
    logic [4:0]  EX_RD_ADDR;
    logic        EX_REG_WE, EX_MEM_WE, EX_MEM_RE;
    logic [1:0]  EX_RF_WR_SEL;
    logic [3:0]  BUBBLE_CNT;

    int checks = 0;
    int failures = 0;

    otter_id_ex_reg #(.XLEN(32), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_IMM(ID_IMM),
        .ID_SRCA_SEL(ID_SRCA_SEL), .ID_SRCB_SEL(ID_SRCB_SEL),
        .ID_ALU_FUN(ID_ALU_FUN), .ID_RD_ADDR(ID_RD_ADDR),
        .ID_REG_WE(ID_REG_WE), .ID_MEM_WE(ID_MEM_WE), .ID_MEM_RE(ID_MEM_RE),
        .ID_RF_WR_SEL(ID_RF_WR_SEL), .STALL(STALL), .FLUSH(FLUSH),
        .ID_READY(ID_READY), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .EX_ALU_SRC_A(EX_ALU_SRC_A), .EX_ALU_SRC_B(EX_ALU_SRC_B),
        .EX_ALU_FUN(EX_ALU_FUN), .EX_RS2(EX_RS2), .EX_RD_ADDR(EX_RD_ADDR),
        .EX_REG_WE(EX_REG_WE), .EX_MEM_WE(EX_MEM_WE), .EX_MEM_RE(EX_MEM_RE),
        .EX_RF_WR_SEL(EX_RF_WR_SEL), .BUBBLE_CNT(BUBBLE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ID_VALID = 0; ID_PC = 0; ID_RS1 = 0; ID_RS2 = 0; ID_IMM = 0;
        ID_SRCA_SEL = 0; ID_SRCB_SEL = 0; ID_ALU_FUN = 0; ID_RD_ADDR = 0;
        ID_REG_WE = 0; ID_MEM_WE = 0; ID_MEM_RE = 0; ID_RF_WR_SEL = 0;
    endtask

    task automatic random_inputs();
        ID_VALID = 1'($urandom); ID_PC = $urandom; ID_RS1 = $urandom;
        ID_RS2 = $urandom; ID_IMM = $urandom;
        ID_SRCA_SEL = 2'($urandom); ID_SRCB_SEL = 2'($urandom);
        ID_ALU_FUN = 4'($urandom); ID_RD_ADDR = 5'($urandom);
        ID_REG_WE = 1'($urandom); ID_MEM_WE = 1'($urandom);
        ID_MEM_RE = 1'($urandom); ID_RF_WR_SEL = 2'($urandom);
    endtask

    // Every EX output and the counter must be zero
    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  32'(EX_VALID), 0);
        check({tag, "_pc"},     EX_PC, 0);
        check({tag, "_a"},      EX_ALU_SRC_A, 0);
        check({tag, "_b"},      EX_ALU_SRC_B, 0);
        check({tag, "_fun"},    32'(EX_ALU_FUN), 0);
        check({tag, "_rs2"},    EX_RS2, 0);
        check({tag, "_rd"},     32'(EX_RD_ADDR), 0);
        check({tag, "_regwe"},  32'(EX_REG_WE), 0);
        check({tag, "_memwe"},  32'(EX_MEM_WE), 0);
        check({tag, "_memre"},  32'(EX_MEM_RE), 0);
        check({tag, "_wrsel"},  32'(EX_RF_WR_SEL), 0);
        check({tag, "_cnt"},    32'(BUBBLE_CNT), 0);
    endtask

    initial begin
        // Reset held two cycles with random ID inputs
        RST = 1; STALL = 0; FLUSH = 0;
        random_inputs();
        tick();
        random_inputs();
        tick();
        check_all_zero("reset");
        check("reset_ready", 32'(ID_READY), 1);

        // Basic load: A = RS1, B = IMM
        RST = 0;
        idle_inputs();
        ID_VALID = 1; ID_RS1 = 32'd5; ID_IMM = 32'd7; ID_RS2 = 32'h55;
        ID_PC = 32'h40; ID_SRCA_SEL = 0; ID_SRCB_SEL = 1; ID_ALU_FUN = 4'b0000;
        ID_REG_WE = 1; ID_RD_ADDR = 5'd3; ID_RF_WR_SEL = 2'd3;
        tick();
        check("load_a", EX_ALU_SRC_A, 32'd5);
        check("load_b", EX_ALU_SRC_B, 32'd7);
        check("load_fun", 32'(EX_ALU_FUN), 0);
        check("load_valid", 32'(EX_VALID), 1);
        check("load_regwe", 32'(EX_REG_WE), 1);
        check("load_rd", 32'(EX_RD_ADDR), 3);
        check("load_rs2", EX_RS2, 32'h55);
        check("load_pc", EX_PC, 32'h40);
        check("load_wrsel", 32'(EX_RF_WR_SEL), 3);
        check("load_cnt", 32'(BUBBLE_CNT), 0);

        // A = PC, B = constant 4
        ID_PC = 32'h100; ID_SRCA_SEL = 1; ID_SRCB_SEL = 2; ID_ALU_FUN = 4'b1000;
        tick();
        check("pc4_a", EX_ALU_SRC_A, 32'h100);
        check("pc4_b", EX_ALU_SRC_B, 32'd4);
        check("pc4_fun", 32'(EX_ALU_FUN), 4'b1000);

        // A = zero, B = RS2
        ID_SRCA_SEL = 2; ID_SRCB_SEL = 0; ID_RS2 = 32'h99; ID_RS1 = 32'h1234;
        tick();
        check("zero_a", EX_ALU_SRC_A, 0);
        check("rs2_b", EX_ALU_SRC_B, 32'h99);

        // Reserved codes select zero on both operands
        ID_SRCA_SEL = 3; ID_SRCB_SEL = 3; ID_RS1 = 32'hdead; ID_IMM = 32'hbeef;
        ID_ALU_FUN = 4'b1101; ID_MEM_RE = 1; ID_RF_WR_SEL = 2'd2;
        tick();
        check("rsvd_a", EX_ALU_SRC_A, 0);
        check("rsvd_b", EX_ALU_SRC_B, 0);
        check("rsvd_fun", 32'(EX_ALU_FUN), 4'b1101);
        check("rsvd_memre", 32'(EX_MEM_RE), 1);
        check("rsvd_wrsel", 32'(EX_RF_WR_SEL), 2);

        // Distinctive load to freeze during the stall
        idle_inputs();
        ID_VALID = 1; ID_RS1 = 32'h11; ID_RS2 = 32'h22; ID_PC = 32'h200;
        ID_SRCA_SEL = 0; ID_SRCB_SEL = 0; ID_ALU_FUN = 4'b0111; ID_RD_ADDR = 5'd9;
        ID_REG_WE = 1;
        tick();
        check("prestall_a", EX_ALU_SRC_A, 32'h11);

        // Stall 3 cycles; inputs change each cycle, one with ID_VALID = 0
        STALL = 1;
        for (int i = 0; i < 3; i++) begin
            ID_RS1 = 32'h1000 + 32'(i); ID_RS2 = 32'h2000 + 32'(i);
            ID_PC = 32'h3000 + 32'(i); ID_ALU_FUN = 4'(i + 1);
            ID_RD_ADDR = 5'(20 + i); ID_VALID = (i != 1);
            #1;
            check("stall_ready", 32'(ID_READY), 0);
            tick();
            check("stall_a", EX_ALU_SRC_A, 32'h11);
            check("stall_b", EX_ALU_SRC_B, 32'h22);
            check("stall_pc", EX_PC, 32'h200);
            check("stall_fun", 32'(EX_ALU_FUN), 4'b0111);
            check("stall_rd", 32'(EX_RD_ADDR), 9);
            check("stall_valid", 32'(EX_VALID), 1);
            check("stall_cnt", 32'(BUBBLE_CNT), 0);
        end

        // Release: the edge loads the ID values present at that edge
        STALL = 0;
        ID_VALID = 1; ID_RS1 = 32'h3333; ID_IMM = 32'h44; ID_SRCA_SEL = 0;
        ID_SRCB_SEL = 1; ID_ALU_FUN = 4'b0110; ID_PC = 32'h204; ID_RD_ADDR = 5'd4;
        #1;
        check("release_ready", 32'(ID_READY), 1);
        tick();
        check("release_a", EX_ALU_SRC_A, 32'h3333);
        check("release_b", EX_ALU_SRC_B, 32'h44);
        check("release_fun", 32'(EX_ALU_FUN), 4'b0110);
        check("release_pc", EX_PC, 32'h204);
        check("release_rd", 32'(EX_RD_ADDR), 4);

        // FLUSH with STALL and a valid store: bubble, counter +1
        STALL = 1; FLUSH = 1;
        ID_VALID = 1; ID_MEM_WE = 1; ID_REG_WE = 1; ID_ALU_FUN = 4'b1010;
        ID_RS1 = 32'h77; ID_RS2 = 32'h88;
        tick();
        check("flush_valid", 32'(EX_VALID), 0);
        check("flush_memwe", 32'(EX_MEM_WE), 0);
        check("flush_regwe", 32'(EX_REG_WE), 0);
        check("flush_fun", 32'(EX_ALU_FUN), 0);
        check("flush_a", EX_ALU_SRC_A, 0);
        check("flush_rs2", EX_RS2, 0);
        check("flush_pc", EX_PC, 0);
        check("flush_cnt", 32'(BUBBLE_CNT), 1);

        // 20 invalid loads: counter climbs from 1 and sticks at 15
        STALL = 0; FLUSH = 0;
        random_inputs();
        ID_VALID = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sat_cnt", 32'(BUBBLE_CNT), (i + 2 > 15) ? 15 : i + 2);
            check("sat_valid", 32'(EX_VALID), 0);
            check("sat_a", EX_ALU_SRC_A, 0);
        end

        // Valid load keeps the saturated count
        idle_inputs();
        ID_VALID = 1; ID_RS1 = 32'h5a; ID_MEM_WE = 1;
        tick();
        check("postsat_a", EX_ALU_SRC_A, 32'h5a);
        check("postsat_memwe", 32'(EX_MEM_WE), 1);
        check("postsat_cnt", 32'(BUBBLE_CNT), 15);

        // Reset during stall and flush wins
        STALL = 1; FLUSH = 1; RST = 1;
        tick();
        check_all_zero("rststall");

        // First load after reset
        RST = 0; STALL = 0; FLUSH = 0;
        idle_inputs();
        ID_VALID = 1; ID_RS1 = 32'hcafe; ID_PC = 32'h80; ID_SRCA_SEL = 1;
        ID_SRCB_SEL = 2; ID_MEM_WE = 1; ID_RD_ADDR = 5'd31;
        tick();
        check("after_a", EX_ALU_SRC_A, 32'h80);
        check("after_b", EX_ALU_SRC_B, 32'd4);
        check("after_memwe", 32'(EX_MEM_WE), 1);
        check("after_rd", 32'(EX_RD_ADDR), 31);
        check("after_cnt", 32'(BUBBLE_CNT), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
